// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop detection on clk_div, one-deep
// holding register read through ce/rd, with framing and overrun flags.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       Rxd,
    input  logic       ce,
    input  logic       rd,
    output logic [7:0] data,
    output logic       dbf,
    output logic       fe,
    output logic       oe,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rxd_m, rxd_s;
    logic             rd_en;

    assign rd_en = ce & rd;
    assign busy  = (state != IDLE);

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_div) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= Rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk_div) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data    <= 8'h00;
            dbf     <= 1'b0;
            fe      <= 1'b0;
            oe      <= 1'b0;
        end else begin
            if (rd_en) begin
                dbf <= 1'b0;
                fe  <= 1'b0;
                oe  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            // A read in the same edge frees the buffer, so the new byte wins.
                            if (!dbf || rd_en) begin
                                data <= shift;
                                dbf  <= 1'b1;
                            end else begin
                                oe <= 1'b1;
                            end
                        end else begin
                            fe    <= 1'b1;
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, an event-scheduled reference model of the
// host-visible outputs checked every cycle, plus literal end-of-test expectations.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int EV_ON = 0, EV_OFF = 1, EV_LOAD = 2, EV_FERR = 3;

    logic       clk_div = 1'b0;
    logic       rst = 1'b0;
    logic       Rxd = 1'b1;
    logic       ce = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       dbf, fe, oe, busy;

    always #5 clk_div = ~clk_div;

    uart_rx #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
        .clk_div(clk_div), .rst(rst), .Rxd(Rxd), .ce(ce), .rd(rd),
        .data(data), .dbf(dbf), .fe(fe), .oe(oe), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int rd_at = -1;
    int last_t0 = 0;
    int dbf_rise = 0;
    int busy_fall = 0;
    logic dbf_q = 1'b0;
    logic busy_q = 1'b0;

    typedef struct {
        int         e;
        int         k;
        logic [7:0] b;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data = 8'h00;
    logic       m_dbf = 1'b0, m_fe = 1'b0, m_oe = 1'b0, m_busy = 1'b0;
    logic       model_ok = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push(input int e, input int k, input logic [7:0] b);
        ev_t x;
        x.e = e; x.k = k; x.b = b;
        evq.push_back(x);
    endtask

    // Advance one edge; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_div);
        #1;
        ce = (edge_cnt + 1 == rd_at);
        rd = (edge_cnt + 1 == rd_at);
    endtask

    task automatic do_read();
        rd_at = edge_cnt + 1;
        ce = 1'b1;
        rd = 1'b1;
        tick();
    endtask

    // Frame timing: the edge that registers the start bit is t0; the stop bit is
    // judged at t0 + 2 (sync) + OS/2 (mid start) + 9*OS.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold, input logic rd_stop);
        int t0, ts;
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        t0 = edge_cnt + 1;
        ts = t0 + 2 + OS / 2 + 9 * OS;
        last_t0 = t0;
        push(t0 + 2, EV_ON, 8'h00);
        if (stop) begin
            push(ts, EV_LOAD, b);
            push(ts, EV_OFF, 8'h00);
        end else begin
            push(ts, EV_FERR, 8'h00);
        end
        if (rd_stop) rd_at = ts;
        for (int i = 0; i < 10; i++) begin
            Rxd = fr[i];
            repeat (OS) tick();
        end
        if (!stop) begin
            repeat (hold) tick();
            Rxd = 1'b1;
            push(edge_cnt + 3, EV_OFF, 8'h00);
        end
        Rxd = 1'b1;
        repeat (OS) tick();
    endtask

    task automatic glitch(input int len);
        int t0;
        t0 = edge_cnt + 1;
        last_t0 = t0;
        push(t0 + 2, EV_ON, 8'h00);
        push(t0 + 2 + OS / 2, EV_OFF, 8'h00);
        Rxd = 1'b0;
        repeat (len) tick();
        Rxd = 1'b1;
        repeat (2 * OS) tick();
    endtask

    // All-ones payload keeps the line high after the abort so nothing retriggers.
    task automatic abort_frame();
        int t0;
        t0 = edge_cnt + 1;
        push(t0 + 2, EV_ON, 8'h00);
        Rxd = 1'b0;
        repeat (OS) tick();
        Rxd = 1'b1;
        repeat (4 * OS + OS / 2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2 * OS) tick();
    endtask

    // Reference model: applies scheduled frame outcomes and observed reads/resets.
    always @(posedge clk_div) begin : model
        int         n;
        logic [7:0] d;
        logic       bf, f, o, bz, rdv;
        n = edge_cnt + 1;
        d = m_data; bf = m_dbf; f = m_fe; o = m_oe; bz = m_busy;
        rdv = ce && rd;
        if (!rst) begin
            d = 8'h00; bf = 1'b0; f = 1'b0; o = 1'b0; bz = 1'b0;
            model_ok <= 1'b1;
        end else if (rdv) begin
            bf = 1'b0; f = 1'b0; o = 1'b0;
        end
        while (evq.size() > 0 && evq[0].e <= n) begin
            if (rst && evq[0].e == n) begin
                case (evq[0].k)
                    EV_ON:   bz = 1'b1;
                    EV_OFF:  bz = 1'b0;
                    EV_FERR: f = 1'b1;
                    default: begin
                        if (!m_dbf || rdv) begin
                            d = evq[0].b;
                            bf = 1'b1;
                        end else begin
                            o = 1'b1;
                        end
                    end
                endcase
            end
            void'(evq.pop_front());
        end
        edge_cnt <= n;
        m_data <= d; m_dbf <= bf; m_fe <= f; m_oe <= o; m_busy <= bz;
    end

    always @(negedge clk_div) begin
        if (model_ok) begin
            chk("data", data, m_data);
            chk("dbf", {7'd0, dbf}, {7'd0, m_dbf});
            chk("fe", {7'd0, fe}, {7'd0, m_fe});
            chk("oe", {7'd0, oe}, {7'd0, m_oe});
            chk("busy", {7'd0, busy}, {7'd0, m_busy});
        end
    end

    always @(negedge clk_div) begin
        if (dbf === 1'b1 && dbf_q !== 1'b1) dbf_rise <= edge_cnt;
        if (busy === 1'b0 && busy_q === 1'b1) busy_fall <= edge_cnt;
        dbf_q <= dbf;
        busy_q <= busy;
    end

    initial begin
        repeat (3) tick();
        chk("rst_data", data, 8'h00);
        chk("rst_flags", {4'd0, dbf, fe, oe, busy}, 8'h00);
        rst = 1'b1;
        repeat (4) tick();

        // 1: clean frame, then read
        send_frame(8'h55, 1'b1, 0, 1'b0);
        chk("t1_data", data, 8'h55);
        chk("t1_flags", {5'd0, dbf, fe, oe}, 8'h04);
        chk("t1_latency", 8'(dbf_rise - last_t0), 8'd154);
        do_read();
        repeat (2) tick();
        chk("t1_read_dbf", {7'd0, dbf}, 8'h00);
        chk("t1_read_data", data, 8'h55);

        // 2: short glitch
        glitch(4);
        chk("t2_busy_fall", 8'(busy_fall - last_t0), 8'd10);
        chk("t2_flags", {4'd0, dbf, fe, oe, busy}, 8'h00);

        // 3: framing error with held-low line, then a good frame without read
        send_frame(8'hA3, 1'b0, 40, 1'b0);
        chk("t3_fe", {4'd0, dbf, fe, oe, busy}, 8'h04);
        chk("t3_data", data, 8'h55);
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        chk("t3_next_data", data, 8'h0F);
        chk("t3_next_flags", {5'd0, dbf, fe, oe}, 8'h06);

        // 4: overrun
        do_read();
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        chk("t4_data", data, 8'h11);
        chk("t4_flags", {5'd0, dbf, fe, oe}, 8'h05);
        do_read();
        tick();
        chk("t4_cleared", {5'd0, dbf, fe, oe}, 8'h00);

        // 5: read coincides with the stop-sample edge of the second frame
        send_frame(8'h11, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        chk("t5_data", data, 8'h22);
        chk("t5_flags", {5'd0, dbf, fe, oe}, 8'h04);

        // 6: reset mid-frame, then a clean frame
        abort_frame();
        chk("t6_rst_data", data, 8'h00);
        chk("t6_rst_flags", {4'd0, dbf, fe, oe, busy}, 8'h00);
        send_frame(8'hC6, 1'b1, 0, 1'b0);
        chk("t6_data", data, 8'hC6);
        chk("t6_flags", {5'd0, dbf, fe, oe}, 8'h04);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
